two_false_bist_ctrl: RTL and testbench
======================================

TWO_FALSE_BIST_CTRL -- requirements
Module: two_false_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles to hold each vector before sampling the detector (legal 1..15).
REQ-002 SHALL have parameter LOOP, default 0; when 1, restart the sweep after DONE instead of going idle.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level-sampled request to begin a sweep; honoured only in IDLE.
REQ-007 abort  input  1  cancel the sweep in progress.
REQ-008 q_in  input  1  detector output under test.
REQ-009 a, b, c  output  1 each  stimulus to detector inputs A, B, C.
REQ-010 busy  output  1  high in APPLY, SETTLE or CHECK.
REQ-011 done  output  1  one-cycle pulse in DONE.
REQ-012 pass  output  1  fail_cnt==0 at last DONE; held until the next accepted start.
REQ-013 fail_cnt  output  4  number of mismatching vectors, range 0..8.
REQ-014 fail_vec  output  3  {a,b,c} of the first mismatch; 3'b000 if none.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-016 IDLE with start=1 SHALL:
- go to APPLY;
- set vec=0;
- clear fail_cnt, fail_vec and pass.
REQ-017 APPLY SHALL drive {a,b,c}=vec for 1 cycle, then go to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles.
REQ-019 {a,b,c} SHALL stay stable from APPLY through CHECK.
REQ-020 CHECK SHALL compare q_in with expected = at least two of {a,b,c} are 0.
REQ-021 On a CHECK mismatch, fail_cnt SHALL increment; fail_vec SHALL capture vec only if fail_cnt was 0.
REQ-022 From CHECK:
- vec==7 goes to DONE;
- otherwise vec increments and the FSM goes to APPLY.
REQ-023 Each vector SHALL take SETTLE_CYCLES+2 cycles; DONE SHALL be entered 8*(SETTLE_CYCLES+2) edges after the edge that accepted start.
REQ-024 DONE SHALL last 1 cycle, then go to IDLE (LOOP=0) or act as an accepted start (LOOP=1).
REQ-025 start asserted while busy or in DONE SHALL be ignored.
REQ-026 abort in APPLY, SETTLE or CHECK SHALL:
- force IDLE on the next edge;
- produce no done pulse;
- leave pass=0;
- retain fail_cnt.
REQ-027 If abort and the final CHECK occur in the same cycle, abort SHALL win.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 In IDLE, {a,b,c} SHALL be 3'b111.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE;
- vec=0;
- {a,b,c}=3'b111;
- busy=0, done=0, pass=0;
- fail_cnt=0, fail_vec=0.
REQ-031 Reset mid-sweep SHALL discard all progress; the next start begins again at vec=0.

Configuration
REQ-032 Macro TFD_STOP_ON_FAIL_EN SHALL control early exit.
- Defined: the first CHECK mismatch goes directly to DONE with fail_cnt=1 and fail_vec=that vector.
- Undefined: all 8 vectors always run.

Structure
REQ-033 Package tfd_pkg SHALL hold:
- the state enum typedef;
- constant TFD_NUM_VECTORS=8;
- pure function tfd_expected(a,b,c).
REQ-034 A combinational sub-module tfd_golden (inputs a, b, c; output exp_q) SHALL compute the expected value; all sequencing SHALL stay in the top module.

Verification
REQ-035 The bench SHALL cover these scenarios:
- Correct detector model, SETTLE_CYCLES=2, start pulse -> done 32 edges later, pass=1, fail_cnt=0, fail_vec=0.
- Detector stuck-at-0 -> expected-1 vectors 000, 001, 010, 100 mismatch -> fail_cnt=4, fail_vec=3'b000, pass=0.
- Detector outputs 1 only for vector 3'b110 (TFD_STOP_ON_FAIL_EN defined) -> DONE after vector 0's CHECK, fail_cnt=1, fail_vec=3'b000.
- abort asserted in SETTLE of vec=5 -> IDLE next edge, no done, {a,b,c}=111, busy=0.
- rst_n pulsed low mid-CHECK of vec=3 -> all outputs at reset values immediately; a new start gives a full 32-cycle sweep.
- LOOP=1 -> a done pulse every 33 cycles; start held high during a sweep has no effect.

Source files
------------

// File: rtl/tfd_pkg.sv
// rtl/tfd_pkg.sv - shared state type, vector count and golden detector function
package tfd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } tfd_state_t;

    localparam int TFD_NUM_VECTORS = 8;

    // Detector truth: high when at least two of the three inputs are low.
    function automatic logic tfd_expected(input logic a, input logic b, input logic c);
        return (!a && !b) || (!a && !c) || (!b && !c);
    endfunction

endpackage

// File: rtl/tfd_golden.sv
// rtl/tfd_golden.sv - combinational golden model of the two-false detector
module tfd_golden
    import tfd_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_q
);

    assign exp_q = tfd_expected(a, b, c);

endmodule

// File: rtl/two_false_bist_ctrl.sv
// rtl/two_false_bist_ctrl.sv - exhaustive 8-vector BIST sequencer for the two-false detector
// Optional early exit on first mismatch: define TFD_STOP_ON_FAIL_EN.
module two_false_bist_ctrl
    import tfd_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit LOOP          = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       q_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [2:0] fail_vec
);

    tfd_state_t state, state_nxt;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic       exp_q;
    logic       mismatch;
    logic       stop_now;
    logic       begin_sweep;
    logic       check_commit;

    assign busy = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign {a, b, c} = busy ? vec : 3'b111;

    tfd_golden u_golden (
        .a     (a),
        .b     (b),
        .c     (c),
        .exp_q (exp_q)
    );

    assign mismatch     = (state == ST_CHECK) && (q_in != exp_q);
    // An abort in the same cycle as a CHECK discards that CHECK's result.
    assign check_commit = (state == ST_CHECK) && !abort;

`ifdef TFD_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        begin_sweep = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                    state_nxt   = ST_APPLY;
                end
            end
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == 4'(SETTLE_CYCLES - 1))
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (vec == 3'(TFD_NUM_VECTORS - 1) || stop_now)
                    state_nxt = ST_DONE;
                else
                    state_nxt = ST_APPLY;
            end
            ST_DONE: begin
                if (LOOP) begin
                    begin_sweep = 1'b1;
                    state_nxt   = ST_APPLY;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort && busy) begin
            state_nxt   = ST_IDLE;
            begin_sweep = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            fail_cnt   <= 4'd0;
            fail_vec   <= 3'd0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
            if (begin_sweep) begin
                vec      <= 3'd0;
                fail_cnt <= 4'd0;
                fail_vec <= 3'd0;
                pass     <= 1'b0;
            end else if (check_commit) begin
                if (mismatch) begin
                    fail_cnt <= fail_cnt + 4'd1;
                    if (fail_cnt == 4'd0)
                        fail_vec <= vec;
                end
                if (state_nxt == ST_DONE)
                    pass <= (fail_cnt == 4'd0) && !mismatch;
                else
                    vec <= vec + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_two_false_bist_ctrl.sv
// tb/tb_two_false_bist_ctrl.sv - randomized self-checking bench for two_false_bist_ctrl
module tb_two_false_bist_ctrl;

    localparam int SC  = 2;
    localparam int PER = SC + 2;
`ifdef TFD_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [7:0] tbl = 8'h17;
    logic       q_in, a, b, c, busy, done, pass;
    logic [3:0] fail_cnt;
    logic [2:0] fail_vec;

    logic       start_l = 1'b0;
    logic [7:0] tbl_l = 8'h17;
    logic       q_l, a_l, b_l, c_l, busy_l, done_l, pass_l;
    logic [3:0] fail_cnt_l;
    logic [2:0] fail_vec_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign q_in = tbl[{a, b, c}];
    assign q_l  = tbl_l[{a_l, b_l, c_l}];

    two_false_bist_ctrl #(.SETTLE_CYCLES(SC), .LOOP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q_in(q_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .fail_vec(fail_vec)
    );

    two_false_bist_ctrl #(.SETTLE_CYCLES(SC), .LOOP(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .abort(1'b0), .q_in(q_l),
        .a(a_l), .b(b_l), .c(c_l), .busy(busy_l), .done(done_l), .pass(pass_l),
        .fail_cnt(fail_cnt_l), .fail_vec(fail_vec_l)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit exp_q(input int v);
        logic [2:0] vv;
        vv = v[2:0];
        return (3 - $countones(vv)) >= 2;
    endfunction

    // Walk the vectors in order; a stop-on-fail build ends at the first mismatch.
    function automatic void model(input logic [7:0] t, input int nvec,
                                  output int cnt, output int fvec, output int last);
        cnt  = 0;
        fvec = 0;
        last = nvec - 1;
        for (int v = 0; v < nvec; v++) begin
            if (t[v] != exp_q(v)) begin
                if (cnt == 0) fvec = v;
                cnt++;
                if (STOP_EN) begin
                    last = v;
                    break;
                end
            end
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_abc"}, {a, b, c}, 7);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_fcnt"}, fail_cnt, 0);
        chk({tag, "_fvec"}, fail_vec, 0);
    endtask

    task automatic run_sweep(input logic [7:0] t, input int hold);
        int ecnt, efv, elast, edone, got, trk;
        model(t, 8, ecnt, efv, elast);
        edone = (elast + 1) * PER;
        got   = -1;
        trk   = 0;
        tbl   = t;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 120 && got < 0; k++) begin
            @(posedge clk);
            #1;
            if (k >= hold) start = 1'b0;
            if (done) got = k;
            else if (k < edone && (busy !== 1'b1 || {a, b, c} !== 3'(k / PER))) trk++;
        end
        start = 1'b0;
        chk("sweep_done_edge", got, edone);
        chk("sweep_track", trk, 0);
        chk("sweep_fcnt", fail_cnt, ecnt);
        chk("sweep_fvec", fail_vec, efv);
        chk("sweep_pass", pass, ecnt == 0);
        @(posedge clk);
        #1;
        chk("post_done_pulse", done, 0);
        chk("post_busy", busy, 0);
        chk("post_abc", {a, b, c}, 7);
        chk("post_pass_held", pass, ecnt == 0);
    endtask

    task automatic run_to_edge(input logic [7:0] t, input int stop_k);
        tbl = t;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= stop_k; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ecnt, efv, elast, ndone, t_prev, nseen;
        logic [7:0] t_ab;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(8'h17, 5);
        run_sweep(8'h00, 2);
        run_sweep(8'h40, 1);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] rt;
            rt = 8'($urandom_range(0, 255));
            run_sweep(rt, 1);
        end
        run_sweep(8'hE8, 1);

        // abort in the first SETTLE cycle of vector 5
        t_ab = STOP_EN ? 8'h97 : 8'h00;
        run_to_edge(t_ab, 5 * PER + 1);
        chk("pre_abort_busy", busy, 1);
        chk("pre_abort_abc", {a, b, c}, 5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        model(t_ab, 5, ecnt, efv, elast);
        chk("abort_busy", busy, 0);
        chk("abort_abc", {a, b, c}, 7);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_fcnt", fail_cnt, ecnt);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // asynchronous reset during the CHECK of vector 3
        run_to_edge(t_ab, 3 * PER + SC + 1);
        chk("pre_reset_abc", {a, b, c}, 3);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(8'h17, 3);

        // LOOP instance: start held high throughout
        @(negedge clk);
        start_l = 1'b1;
        @(posedge clk);
        t_prev = 0;
        nseen  = 0;
        for (int k = 1; k <= 200 && nseen < 4; k++) begin
            @(posedge clk);
            #1;
            if (done_l) begin
                chk("loop_period", k - t_prev, (nseen == 0) ? 8 * PER : 8 * PER + 1);
                chk("loop_pass", pass_l, 1);
                t_prev = k;
                nseen++;
            end
        end
        chk("loop_pulses", nseen, 4);
        start_l = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
